// File: rtl/ccff_chain_loader.sv
// Configuration-chain bitstream writer: serializes valid/ready words MSB-first onto ccff_head,
// gates the chain shift enable, and optionally counts ccff_tail mismatches on a second pass.
module ccff_chain_loader #(
  parameter  int CHAIN_LEN = 16,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int BW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              verify_r;
  logic [WORD_W-1:0] buf_word;
  logic [BW-1:0]     buf_cnt;
  logic [CNT_W-1:0]  iss;      // bits taken from the buffer in the current pass
  logic [CNT_W-1:0]  bit_cnt;  // enabled (shifted) cycles in the current pass

  logic              active, pop, pass_full, last_en, next_pass_pending;
  logic              buf_free, accept;
  logic [CNT_W-1:0]  iss_p, base;
  logic [31:0]       rem;
  logic [BW-1:0]     load_cnt;

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    state_nxt         = state;
    active            = (state == S_LOAD) || (state == S_VERIFY);
    pop               = active && (buf_cnt != '0) && (iss != CNT_W'(CHAIN_LEN));
    iss_p             = iss + CNT_W'(pop);
    pass_full         = (iss_p == CNT_W'(CHAIN_LEN));
    last_en           = prog_clk_en && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    next_pass_pending = (state == S_LOAD) && verify_r;
    buf_free          = (buf_cnt == '0) || (pop && (buf_cnt == BW'(1)));
    s_ready           = active && buf_free && (!pass_full || next_pass_pending);
    accept            = s_valid && s_ready;
    // A word accepted after the pass is fully issued belongs to the next pass.
    base              = pass_full ? '0 : iss_p;
    rem               = 32'(CHAIN_LEN) - 32'(base);
    // Clamping the usable count drops the unused low bits of a pass's final word.
    load_cnt          = (rem >= 32'(WORD_W)) ? BW'(WORD_W) : BW'(rem);

    unique case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   if (last_en) state_nxt = verify_r ? S_VERIFY : S_DONE;
      S_VERIFY: if (last_en) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_LOAD) || (state == S_VERIFY);
  assign done = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from
  // the same pre-edge values.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      // NOTE: the word buffer is a handful of flops, so its data is reset along with its count.
      state       <= S_IDLE;
      verify_r    <= 1'b0;
      buf_word    <= '0;
      buf_cnt     <= '0;
      iss         <= '0;
      bit_cnt     <= '0;
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      prog_clk_en <= pop;
      if (pop) ccff_head <= buf_word[WORD_W-1];

      if (state == S_IDLE) begin
        if (start) begin
          verify_r <= verify;
          err_cnt  <= '0;
          bit_cnt  <= '0;
          iss      <= '0;
          buf_cnt  <= '0;
        end
      end else begin
        if (accept) begin
          buf_word <= s_data;
          buf_cnt  <= load_cnt;
        end else if (pop) begin
          buf_word <= buf_word << 1;
          buf_cnt  <= buf_cnt - BW'(1);
        end

        if (last_en) begin
          bit_cnt <= '0;
          iss     <= '0;
        end else begin
          iss <= iss_p;
          if (prog_clk_en) bit_cnt <= bit_cnt + CNT_W'(1);
        end

        // ccff_tail still shows the pre-shift bit while the matching head bit is presented.
        if ((state == S_VERIFY) && prog_clk_en && (ccff_tail != ccff_head) && (err_cnt != '1))
          err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
